fp_range_reduce: RTL
====================

# fp_range_reduce

Upstream argument-reduction stage for the `sincos` series evaluator. It accepts one IEEE-754 single-precision angle `x` and returns `r = x − 2π·round(x/2π)` as FP32, so that `r` lies in [−π, π], the range where the 11th/12th-order Taylor polynomials stay accurate. The block is a multi-cycle iterative FSM with a valid/ready handshake on each side. Its output drives the `sincos` `opx` input.

## Interface
Parameters:
- `INV2PI` — default 32'h28BE60DC — 1/(2π) as unsigned Q0.32.
- `TWOPI` — default 32'hC90FDAA2 — 2π as unsigned Q3.29.
- `PI_BITS` — default 32'h40490FDB — FP32 encoding of π; the bypass threshold.

Ports:
- `clk` — in — 1 — single clock; all state changes on the rising edge.
- `rst` — in — 1 — reset, asynchronous and active-high.
- `in_valid` — in — 1 — `in_x` is valid.
- `in_ready` — out — 1 — block can accept a value; high only in IDLE.
- `in_x` — in — 32 — FP32 angle.
- `out_valid` — out — 1 — `out_r` and `out_err` are valid.
- `out_ready` — in — 1 — consumer accepts the result.
- `out_r` — out — 32 — FP32 reduced angle.
- `out_err` — out — 1 — input was out of range, NaN or Inf.

## Operation
- States: IDLE, CLASS, MUL1, FRAC, MUL2, NORM, OUT.
- **IDLE:** when `in_valid & in_ready`, latch `in_x`, then go to CLASS.
- **CLASS:** let `e` = exponent and `m` = {1, mantissa}.
  - `e == 255` (NaN/Inf) → `err = 1`, `r = 0`, go to OUT.
  - `e > 150` (|x| ≥ 2^24) → `err = 1`, `r = 0`, go to OUT.
  - `|x| ≤ PI_BITS`, compared on bits [30:0] → `r = x` unchanged (bypass; includes zero and denormals), go to OUT.
  - Otherwise go to MUL1.
- **MUL1:** `p[55:0] = m × INV2PI`. Let `s = e − 127`, with 1 ≤ s ≤ 23. The value of `x/2π` is `p·2^(s−55)`.
- **FRAC:** take the top 32 fraction bits, `u = p[54−s −: 32]`.
  - Reinterpret `u` as signed; this is `f = x/2π − round(x/2π)` in [−0.5, 0.5).
  - Form magnitude `a = |f|` (33-bit safe) and `fs = sign(f)`.
- **MUL2:** `q[63:0] = a × TWOPI`. The value of `|r|` is `q·2^−61`.
- **NORM:**
  - Leading-one position `k` of `q`.
  - Mantissa = `q[k−1 −: 23]`, truncated with no rounding.
  - Exponent = `127 + k − 61`.
  - Sign = `x_sign ^ fs`.
  - If `q == 0`, the result is `+0`.
  - Go to OUT.
- **OUT:** hold `out_valid = 1` with stable `out_r` and `out_err` until `out_ready`. On the handshake cycle, return to IDLE.
- Accuracy target: error of at most 4 ulp versus exact reduction for non-bypass inputs.

## Timing
- Reset values: state = IDLE, `in_ready = 1`, `out_valid = 0`, `out_r = 0`, `out_err = 0`. All internal registers are cleared.
- Latency is counted from the accept edge to the first cycle `out_valid` is high:
  - Normal path: 5 cycles (CLASS, MUL1, FRAC, MUL2, NORM).
  - Bypass and error paths: 1 cycle.
- `in_ready` is low from the accept edge until the OUT handshake completes. A new accept occurs at the earliest one cycle after the output handshake.
- Maximum throughput on the normal path: one result per 7 cycles.
- `out_valid`, `out_r` and `out_err` are registered. They must not change while `out_valid & !out_ready`.
- `in_valid` is ignored outside IDLE; `in_x` is sampled only on the accept edge.
- If `rst` asserts mid-operation, it immediately forces the reset values and the in-flight transaction is discarded. There is no output after reset deassertion until a new accept.
- `out_err` and `out_valid` assert together. `out_err` deasserts on the handshake.

## Test plan
- **Bypass:** accept `in_x = 3F800000` (1.0) → 1 cycle later `out_valid = 1`, `out_r = 3F800000`, `out_err = 0`. Repeat with `40490FDB` (π) → `out_r = 40490FDB`.
- **Normal reduction:** `in_x = 40800000` (4.0) → after 5 cycles, `out_r` is about −2.2831853 (`C0121FB3` ±4 ulp). `in_x = C1200000` (−10.0) → `out_r` is about +2.5663706 (±4 ulp).
- **Errors:** `in_x = 4CBEBC20` (1e8) → `out_err = 1`, `out_r = 0`, latency 1. `in_x = 7FC00000` (NaN) → same response. `in_x = FF800000` (−Inf) → same response.
- **Backpressure:** hold `out_ready = 0` for 3 cycles after `out_valid` rises → `out_r` is stable and `in_ready = 0` throughout. On the `out_ready` pulse, the next cycle shows `in_ready = 1` and `out_valid = 0`.
- **Reset mid-flight:** accept 4.0, assert `rst` asynchronously in the MUL2 state → outputs go to reset values without waiting for a clock edge. After release, no `out_valid` appears until a new input is accepted.
- **Sweep:** 1000 random `|x| < 2^20`, compared against a `$bitstoshortreal`-based reference model (reduce in double precision) → every result within 4 ulp and within [−π, π].

Source files
------------

// File: rtl/fp_range_reduce_if.sv
// Handshake bundle between an angle producer, fp_range_reduce and its consumer.
// The master drives the input side and accepts results; the slave is the reducer.
interface fp_range_reduce_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_r;
   logic        out_err;

   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_r, out_err
   );

   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_r, out_err
   );
endinterface

// File: rtl/fp_range_reduce.sv
// Iterative FP32 argument reduction r = x - 2*pi*round(x/2*pi) feeding the sincos evaluator.
// Fixed-point datapath: m*INV2PI gives x/2pi, its fraction times TWOPI gives |r|.
module fp_range_reduce #(
   parameter logic [31:0] INV2PI  = 32'h28BE60DC,
   parameter logic [31:0] TWOPI   = 32'hC90FDAA2,
   parameter logic [31:0] PI_BITS = 32'h40490FDB
) (
   input logic              clk,
   input logic              rst,
   fp_range_reduce_if.slave bus_io
);

   typedef enum logic [2:0] {
      StIdle, StClass, StMul1, StFrac, StMul2, StNorm, StOut
   } state_e;

   state_e      state_q;
   logic [31:0] x_q;
   logic [55:0] p_q;
   logic [31:0] a_q;
   logic        fs_q;
   logic [63:0] q_q;
   logic        out_valid_q;
   logic [31:0] out_r_q;
   logic        out_err_q;

   logic [7:0]  exp_x;
   logic [23:0] mant_x;
   logic [7:0]  frac_sh;
   logic [31:0] u;
   logic [55:0] p_d;
   logic [31:0] a_d;
   logic [63:0] q_d;
   logic [5:0]  lead;
   logic [22:0] norm_mant;
   logic [7:0]  norm_exp;

   assign exp_x  = x_q[30:23];
   assign mant_x = {1'b1, x_q[22:0]};

   assign p_d = {32'd0, mant_x} * {24'd0, INV2PI};

   // Fraction bits of x/2pi sit at p[54-s -: 32]; shifting by 23-s = 150-e aligns them at bit 0.
   assign frac_sh = 8'd150 - exp_x;
   assign u       = 32'(p_q >> frac_sh);
   // Magnitude of the signed fraction; 0x80000000 maps onto itself as an unsigned value.
   assign a_d     = u[31] ? (~u + 32'd1) : u;

   assign q_d = {32'd0, a_q} * {32'd0, TWOPI};

   always_comb begin
      lead = '0;
      for (int i = 0; i < 64; i++) begin
         if (q_q[i]) lead = 6'(i);
      end
   end

   assign norm_mant = 23'((q_q << (6'd63 - lead)) >> 40);
   assign norm_exp  = {2'b00, lead} + 8'd66;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         x_q         <= '0;
         p_q         <= '0;
         a_q         <= '0;
         fs_q        <= 1'b0;
         q_q         <= '0;
         out_valid_q <= 1'b0;
         out_r_q     <= '0;
         out_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.in_valid) begin
                  x_q     <= bus_io.in_x;
                  state_q <= StClass;
               end
            end
            StClass: begin
               // e > 150 also covers NaN/Inf (e == 255): both report an error with r = 0.
               if (exp_x > 8'd150) begin
                  out_err_q   <= 1'b1;
                  out_r_q     <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end else if (x_q[30:0] <= PI_BITS[30:0]) begin
                  out_r_q     <= x_q;
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end else begin
                  state_q <= StMul1;
               end
            end
            StMul1: begin
               p_q     <= p_d;
               state_q <= StFrac;
            end
            StFrac: begin
               a_q     <= a_d;
               fs_q    <= u[31];
               state_q <= StMul2;
            end
            StMul2: begin
               q_q     <= q_d;
               state_q <= StNorm;
            end
            StNorm: begin
               out_r_q     <= (q_q == '0) ? '0 : {x_q[31] ^ fs_q, norm_exp, norm_mant};
               out_valid_q <= 1'b1;
               state_q     <= StOut;
            end
            StOut: begin
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  out_err_q   <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.in_ready  = (state_q == StIdle);
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_r     = out_r_q;
   assign bus_io.out_err   = out_err_q;

endmodule
